// File: rtl/rr_mux_pkg.sv
// Shared types and sizes for the 16-way round-robin mux scheduler.
package rr_mux_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_16to1.sv
// Plain 16:1 single-bit multiplexer used in the scheduler datapath.
module mux_16to1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin 16-requester grant FSM feeding a registered 16:1 data mux.
// Optional grant-hold timeout is enabled by defining RR_SCHED_TIMEOUT_EN.
module rr_mux_scheduler
  import rr_mux_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        out,
  output logic        out_valid,
  output logic        timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be within 1..255");
  end

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] win_s;
  logic             mux_s;
  logic             req_sel_s;

  // First requesting index strictly after p, wrapping; p itself is the last candidate.
  function automatic logic [SEL_W-1:0] rr_search(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = p;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_sel_s = req[sel];

  // Winner of the round-robin search for the current request vector.
  always_comb begin
    win_s = rr_search(req, ptr_r);
  end

  mux_16to1 u_mux (
    .in  (in),
    .sel (sel),
    .out (mux_s)
  );

`ifdef RR_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;
  logic             hold_hit_s;

  assign hold_hit_s = ((cnt_r + 8'd1) == CNT_W'(MAX_HOLD));
  assign timeout    = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  // Grant FSM plus the output data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt       <= 16'h0000;
      sel       <= 4'd0;
      ptr_r     <= 4'd15;
      out       <= 1'b0;
      out_valid <= 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
`endif
    end else begin
      out       <= mux_s;
      out_valid <= (state_r == GRANT) && req_sel_s;
`ifdef RR_SCHED_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (req != 16'h0000) begin
            state_r <= GRANT;
            gnt     <= 16'h0001 << win_s;
            sel     <= win_s;
            ptr_r   <= win_s;
`ifdef RR_SCHED_TIMEOUT_EN
            cnt_r   <= 8'd0;
`endif
          end else begin
            gnt <= 16'h0000;
          end
        end
        GRANT: begin
          // A normal release wins over a hold-limit hit on the same edge.
          if (!req_sel_s) begin
            state_r <= IDLE;
            gnt     <= 16'h0000;
          end
`ifdef RR_SCHED_TIMEOUT_EN
          else if (hold_hit_s) begin
            state_r   <= IDLE;
            gnt       <= 16'h0000;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
`else
          else begin
            gnt <= gnt;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          gnt     <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Directed self-checking bench for rr_mux_scheduler (MAX_HOLD=4).
module tb_rr_mux_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] in;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        out;
  logic        out_valid;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;

  rr_mux_scheduler #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    in    = 16'h0000;

    // Reset state, then idle with no requests
    tick();
    tick();
    chk("rst_gnt", gnt, 16'h0000);
    chk("rst_sel", {12'h000, sel}, 16'h0000);
    chk("rst_ov", {15'h0, out_valid}, 16'h0000);
    chk("rst_out", {15'h0, out}, 16'h0000);
    chk("rst_to", {15'h0, timeout}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt", gnt, 16'h0000);
      chk("idle_ov", {15'h0, out_valid}, 16'h0000);
    end

    // req=0009 from reset: requester 0 first, then 3 after a dead cycle
    rst_n = 1'b0;
    req   = 16'h0009;
    tick();
    rst_n = 1'b1;
    tick();
    chk("g0_gnt", gnt, 16'h0001);
    chk("g0_sel", {12'h000, sel}, 16'h0000);
    chk("g0_ov_lag", {15'h0, out_valid}, 16'h0000);
    tick();
    chk("g0_hold", gnt, 16'h0001);
    chk("g0_ov", {15'h0, out_valid}, 16'h0001);
    req = 16'h0008;
    tick();
    chk("dead_gnt", gnt, 16'h0000);
    chk("dead_ov", {15'h0, out_valid}, 16'h0000);
    tick();
    chk("g3_gnt", gnt, 16'h0008);
    chk("g3_sel", {12'h000, sel}, 16'h0003);

    // Wrap fairness: ptr=15, req=8001 -> 0, 15, 0
    rst_n = 1'b0;
    req   = 16'h8001;
    tick();
    rst_n = 1'b1;
    tick();
    chk("wrap_a", gnt, 16'h0001);
    req = 16'h8000;
    tick();
    chk("wrap_rel_a", gnt, 16'h0000);
    req = 16'h8001;
    tick();
    chk("wrap_b", gnt, 16'h8000);
    chk("wrap_b_sel", {12'h000, sel}, 16'h000F);
    req = 16'h0001;
    tick();
    chk("wrap_rel_b", gnt, 16'h0000);
    req = 16'h8001;
    tick();
    chk("wrap_c", gnt, 16'h0001);
    chk("wrap_c_sel", {12'h000, sel}, 16'h0000);

    // Data path on sel=5
    rst_n = 1'b0;
    req   = 16'h0020;
    in    = 16'h0020;
    tick();
    rst_n = 1'b1;
    tick();
    chk("d5_gnt", gnt, 16'h0020);
    chk("d5_sel", {12'h000, sel}, 16'h0005);
    chk("d5_ov_lag", {15'h0, out_valid}, 16'h0000);
    tick();
    chk("d5_out1", {15'h0, out}, 16'h0001);
    chk("d5_ov1", {15'h0, out_valid}, 16'h0001);
    in = 16'h0000;
    tick();
    chk("d5_out0", {15'h0, out}, 16'h0000);
    chk("d5_ov2", {15'h0, out_valid}, 16'h0001);

    // Reset mid-grant aborts everything
    in    = 16'h0020;
    rst_n = 1'b0;
    tick();
    chk("mr_gnt", gnt, 16'h0000);
    chk("mr_sel", {12'h000, sel}, 16'h0000);
    chk("mr_out", {15'h0, out}, 16'h0000);
    chk("mr_ov", {15'h0, out_valid}, 16'h0000);
    chk("mr_to", {15'h0, timeout}, 16'h0000);
    in  = 16'h0000;
    req = 16'h0000;
    rst_n = 1'b1;
    tick();

    // Hold limit with req=0006 held
    rst_n = 1'b0;
    req   = 16'h0006;
    tick();
    rst_n = 1'b1;
    tick();
    chk("h1_gnt", gnt, 16'h0002);
    chk("h1_sel", {12'h000, sel}, 16'h0001);
`ifdef RR_SCHED_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h1_hold", gnt, 16'h0002);
      chk("h1_to0", {15'h0, timeout}, 16'h0000);
    end
    tick();
    chk("to_gnt", gnt, 16'h0000);
    chk("to_pulse", {15'h0, timeout}, 16'h0001);
    tick();
    chk("h2_gnt", gnt, 16'h0004);
    chk("h2_sel", {12'h000, sel}, 16'h0002);
    chk("h2_to", {15'h0, timeout}, 16'h0000);
    // Normal release on the limit edge beats the timeout
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h2_hold", gnt, 16'h0004);
    end
    req = 16'h0002;
    tick();
    chk("prec_gnt", gnt, 16'h0000);
    chk("prec_to", {15'h0, timeout}, 16'h0000);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_inf", gnt, 16'h0002);
      chk("to_tied", {15'h0, timeout}, 16'h0000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
